// File: rtl/debug_unit_controller.sv
// Host-side debug sequencer for the MIPS pipeline: decodes UART command bytes,
// gates the pipeline step enable and streams a full state snapshot back out.
module debug_unit_controller #(
    parameter int NB              = 32,
    parameter int NB_REG_SEL      = 5,
    parameter int N_REGS          = 32,
    parameter int TAM_DATA_MEMORY = 16,
    parameter int NB_BYTE         = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NB_BYTE-1:0]    i_rx_data,
    input  logic                  i_rx_valid,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_step,
    output logic [NB_REG_SEL-1:0] o_debug_mips_register_number,
    output logic [NB-1:0]         o_debug_address,
    input  logic [NB-1:0]         i_mips_pc,
    input  logic [NB-1:0]         i_mips_alu_result,
    input  logic [NB-1:0]         i_mips_register_data,
    input  logic [NB-1:0]         i_mips_data_memory,
    input  logic                  i_halt,
    output logic                  o_busy
);

    localparam int N_WORDS = 2 + N_REGS + TAM_DATA_MEMORY;
    localparam int NB_IDX  = $clog2(N_WORDS);
    localparam int N_BYTES = NB / NB_BYTE;
    localparam int NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [NB_IDX-1:0]  IDX_ALU   = NB_IDX'(1);
    localparam logic [NB_IDX-1:0]  IDX_REG0  = NB_IDX'(2);
    localparam logic [NB_IDX-1:0]  IDX_MEM0  = NB_IDX'(2 + N_REGS);
    localparam logic [NB_IDX-1:0]  IDX_LAST  = NB_IDX'(N_WORDS - 1);
    localparam logic [NB_BCNT-1:0] BYTE_LAST = NB_BCNT'(N_BYTES - 1);

    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'('h53);
    localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'('h52);
    localparam logic [NB_BYTE-1:0] CMD_DUMP = NB_BYTE'('h44);
    localparam logic [NB_BYTE-1:0] CMD_HALT = NB_BYTE'('h48);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_RUN,
        ST_SEL,
        ST_SETTLE,
        ST_LATCH,
        ST_SEND
    } state_t;

    state_t                 state_q, state_d;
    logic [NB_IDX-1:0]      idx_q, idx_d;
    logic [NB_BCNT-1:0]     byte_cnt_q, byte_cnt_d;
    logic [NB-1:0]          shift_q, shift_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [NB_REG_SEL-1:0]  reg_sel_q, reg_sel_d;
    logic [NB-1:0]          addr_q, addr_d;
    logic [NB-1:0]          pc_q, pc_d;
    logic [NB-1:0]          alu_q, alu_d;
    logic                   step_d;
    logic                   run_exit;

    assign run_exit = i_halt || (i_rx_valid && (i_rx_data == CMD_HALT));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        tx_valid_d = tx_valid_q;
        reg_sel_d  = reg_sel_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        alu_d      = alu_q;
        step_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_STEP) begin
                        state_d = i_halt ? ST_SEL : ST_STEP;
                    end else if (i_rx_data == CMD_RUN) begin
                        state_d = i_halt ? ST_SEL : ST_RUN;
                    end else if (i_rx_data == CMD_DUMP) begin
                        state_d = ST_SEL;
                    end
                end
            end
            ST_STEP: begin
                step_d  = 1'b1;
                state_d = ST_SEL;
            end
            ST_RUN: begin
                // The exit condition gates the step in the same cycle so the
                // pipeline never advances past HALT or the host's stop request.
                if (run_exit) begin
                    state_d = ST_SEL;
                end else begin
                    step_d = 1'b1;
                end
            end
            ST_SEL: begin
                // First dump cycle: the pipeline has already absorbed any final
                // step, so PC/ALU are captured here as the snapshot values.
                if (idx_q == '0) begin
                    pc_d  = i_mips_pc;
                    alu_d = i_mips_alu_result;
                end
                if (idx_q >= IDX_MEM0) begin
                    addr_d = NB'(idx_q - IDX_MEM0) << 2;
                end else if (idx_q >= IDX_REG0) begin
                    reg_sel_d = NB_REG_SEL'(idx_q - IDX_REG0);
                end
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (idx_q == '0) begin
                    shift_d = pc_q;
                end else if (idx_q == IDX_ALU) begin
                    shift_d = alu_q;
                end else if (idx_q < IDX_MEM0) begin
                    shift_d = i_mips_register_data;
                end else begin
                    shift_d = i_mips_data_memory;
                end
                tx_valid_d = 1'b1;
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_valid_q && i_tx_ready) begin
                    if (byte_cnt_q == BYTE_LAST) begin
                        tx_valid_d = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + NB_IDX'(1);
                            state_d = ST_SEL;
                        end
                    end else begin
                        shift_d    = shift_q << NB_BYTE;
                        byte_cnt_d = byte_cnt_q + NB_BCNT'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tx_valid_q <= 1'b0;
            reg_sel_q  <= '0;
            addr_q     <= '0;
            pc_q       <= '0;
            alu_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tx_valid_q <= tx_valid_d;
            reg_sel_q  <= reg_sel_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            alu_q      <= alu_d;
        end
    end

    // Transmit byte comes straight from the shift register MSB lane, so it
    // depends only on flops and never on i_tx_ready.
    assign o_tx_data                    = shift_q[NB-1 -: NB_BYTE];
    assign o_tx_valid                   = tx_valid_q;
    assign o_step                       = step_d;
    assign o_debug_mips_register_number = reg_sel_q;
    assign o_debug_address              = addr_q;
    assign o_busy                       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_unit_controller.sv
// Directed bench for debug_unit_controller with a small pipeline model
// (PC advances by 4 per step, GPR/memory read combinationally).
module tb_debug_unit_controller;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        step;
    logic [4:0]  reg_sel;
    logic [31:0] dbg_addr;
    logic [31:0] pc_m = 32'd0;
    logic [31:0] alu_m;
    logic [31:0] reg_data;
    logic [31:0] mem_data;
    logic        halt;
    logic        busy;

    logic [31:0] regs_m [32];
    logic [31:0] mem_m  [16];

    int errors = 0;
    int checks = 0;

    int          nbytes = 0;
    int          step_total = 0;
    int          stab_err = 0;
    logic [7:0]  bytes_seen [4096];
    logic        stall_q = 1'b0;
    logic [7:0]  prev_data = 8'd0;

    debug_unit_controller dut (
        .i_clk                        (clk),
        .i_reset                      (rst),
        .i_rx_data                    (rx_data),
        .i_rx_valid                   (rx_valid),
        .o_tx_data                    (tx_data),
        .o_tx_valid                   (tx_valid),
        .i_tx_ready                   (tx_ready),
        .o_step                       (step),
        .o_debug_mips_register_number (reg_sel),
        .o_debug_address              (dbg_addr),
        .i_mips_pc                    (pc_m),
        .i_mips_alu_result            (alu_m),
        .i_mips_register_data         (reg_data),
        .i_mips_data_memory           (mem_data),
        .i_halt                       (halt),
        .o_busy                       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign alu_m    = pc_m + 32'h100;
    assign reg_data = regs_m[reg_sel];
    assign mem_data = mem_m[dbg_addr[5:2]];

    always @(posedge clk) begin
        if (step) pc_m <= pc_m + 32'd4;
    end

    // Observes the link mid-cycle: anything valid&&ready here transfers at the next edge.
    always @(negedge clk) begin
        if (step) step_total <= step_total + 1;
        if (tx_valid && tx_ready) begin
            bytes_seen[nbytes] <= tx_data;
            nbytes <= nbytes + 1;
        end
        if (!rst && stall_q && (!tx_valid || tx_data != prev_data)) stab_err <= stab_err + 1;
        stall_q   <= tx_valid && !tx_ready && !rst;
        prev_data <= tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input bit toggle);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            if (toggle) tx_ready = ~tx_ready;
            tick();
            n++;
        end
        tx_ready = 1'b1;
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] word_at(input int i);
        return {bytes_seen[i], bytes_seen[i+1], bytes_seen[i+2], bytes_seen[i+3]};
    endfunction

    function automatic int stream_mism(input int base, input logic [31:0] pcv);
        int m;
        logic [31:0] w;
        m = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 0)      w = pcv;
            else if (k == 1) w = pcv + 32'h100;
            else if (k < 34) w = regs_m[k-2];
            else             w = mem_m[k-34];
            if (word_at(base + 4*k) !== w) m++;
        end
        return m;
    endfunction

    int bb;
    int sb;
    int sv;
    int n;

    initial begin
        for (int i = 0; i < 32; i++) regs_m[i] = {8'(i), 8'hC0, 8'(i*3), 8'h11};
        regs_m[0] = 32'd0;
        regs_m[7] = 32'd2;
        for (int j = 0; j < 16; j++) mem_m[j] = {8'(8'hD0 + j), 8'(j), 8'h5A, 8'(255 - j)};
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; halt = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_reg_sel", 32'(reg_sel), 32'd0);
        chk("rst_addr", dbg_addr, 32'd0);
        rst = 1'b0;
        $display("reset released");

        // Quiet idle
        bb = nbytes; sb = step_total;
        repeat (20) tick();
        chk("idle_bytes", nbytes - bb, 32'd0);
        chk("idle_steps", step_total - sb, 32'd0);
        $display("idle 20 cycles: bytes=%0d steps=%0d", nbytes - bb, step_total - sb);

        // STEP from PC=0
        bb = nbytes; sb = step_total;
        send_rx(8'h53);
        wait_idle(1'b0);
        chk("S_steps", step_total - sb, 32'd1);
        chk("S_bytes", nbytes - bb, 32'd200);
        chk("S_pc_word", word_at(bb), 32'h0000_0004);
        chk("S_alu_word", word_at(bb + 4), 32'h0000_0104);
        chk("S_gpr0_word", word_at(bb + 8), 32'h0000_0000);
        chk("S_stream", stream_mism(bb, 32'h4), 32'd0);
        chk("S_busy_end", 32'(busy), 32'd0);
        chk("S_valid_end", 32'(tx_valid), 32'd0);
        $display("cmd S: steps=%0d bytes=%0d pc=%08h", step_total - sb, nbytes - bb, word_at(bb));

        // DUMP with ready toggling
        bb = nbytes; sb = step_total; sv = stab_err;
        send_rx(8'h44);
        wait_idle(1'b1);
        chk("D_bytes", nbytes - bb, 32'd200);
        chk("D_gpr7_word", word_at(bb + 36), 32'h0000_0002);
        chk("D_stable", stab_err - sv, 32'd0);
        chk("D_steps", step_total - sb, 32'd0);
        chk("D_stream", stream_mism(bb, 32'h4), 32'd0);
        $display("cmd D toggled: bytes=%0d gpr7=%08h", nbytes - bb, word_at(bb + 36));

        // RUN then halt after 10 step cycles
        bb = nbytes; sb = step_total;
        send_rx(8'h52);
        repeat (10) tick();
        halt = 1'b1;
        #1;
        chk("R_halt_gate", 32'(step), 32'd0);
        wait_idle(1'b0);
        chk("R_steps", step_total - sb, 32'd10);
        chk("R_bytes", nbytes - bb, 32'd200);
        chk("R_pc_word", word_at(bb), 32'h0000_002C);
        $display("cmd R halt: steps=%0d bytes=%0d pc=%08h", step_total - sb, nbytes - bb, word_at(bb));

        // STEP while halted
        bb = nbytes; sb = step_total;
        send_rx(8'h53);
        wait_idle(1'b0);
        chk("SH_steps", step_total - sb, 32'd0);
        chk("SH_bytes", nbytes - bb, 32'd200);
        chk("SH_pc_word", word_at(bb), 32'h0000_002C);
        halt = 1'b0;
        $display("cmd S halted: steps=%0d bytes=%0d", step_total - sb, nbytes - bb);

        // RUN, 'X' ignored, 'H' stops the same cycle, 'R' in dump ignored
        bb = nbytes; sb = step_total;
        send_rx(8'h52);
        tick();
        send_rx(8'h58);
        tick();
        rx_data = 8'h48; rx_valid = 1'b1;
        #1;
        chk("H_gate", 32'(step), 32'd0);
        tick();
        rx_valid = 1'b0; rx_data = 8'h00;
        repeat (5) tick();
        send_rx(8'h52);
        wait_idle(1'b0);
        repeat (4) tick();
        chk("H_steps", step_total - sb, 32'd3);
        chk("H_bytes", nbytes - bb, 32'd200);
        chk("H_pc_word", word_at(bb), 32'h0000_0038);
        chk("H_busy_after", 32'(busy), 32'd0);
        $display("cmd R/X/H: steps=%0d bytes=%0d pc=%08h", step_total - sb, nbytes - bb, word_at(bb));

        // Reset in the middle of a dump
        bb = nbytes;
        send_rx(8'h44);
        n = 0;
        while (nbytes - bb < 57 && n < 2000) begin
            tick();
            n++;
        end
        chk("mid_reach_57", 32'(nbytes - bb >= 57), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        $display("reset at byte %0d: valid=%0b busy=%0b", nbytes - bb, tx_valid, busy);
        tick();
        bb = nbytes;
        send_rx(8'h44);
        wait_idle(1'b0);
        chk("restart_bytes", nbytes - bb, 32'd200);
        chk("restart_pc_word", word_at(bb), 32'h0000_0038);
        chk("restart_stream", stream_mism(bb, 32'h38), 32'd0);
        $display("dump after reset: bytes=%0d pc=%08h", nbytes - bb, word_at(bb));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
